// File: rtl/router_port_rx.sv
// router_port_rx
// ---------------------------------------------------------------------------
// Receives the serial output side of a router port. Bits arrive LSB first and
// are framed by frameo_n and valido_n, both active low. Each byte is assembled
// in a shift register and pushed, tagged with last/err flags, into a
// first-word-fall-through FIFO. The consumer drains the FIFO with a
// valid/ready handshake.
//
// Parameters
//   FIFO_DEPTH  number of byte entries in the receive FIFO (power of 2, >= 4)
//
// Ports
//   clock       single clock; all state updates on its rising edge
//   reset_n     synchronous active-low reset
//   frameo_n    router frame, active low
//   valido_n    router bit valid, active low
//   dout        router serial data, LSB first
//   byte_data   head-of-FIFO data byte (0 while the FIFO is empty)
//   byte_last   head byte ends a packet
//   byte_err    head byte closes an aborted or partial packet
//   byte_valid  FIFO is non-empty
//   byte_ready  consumer accepts the head entry this cycle
//   pkt_count   number of cleanly terminated packets (wraps at 16 bits)
//   overflow    sticky flag, set when an entry is dropped on a full FIFO
// ---------------------------------------------------------------------------
module router_port_rx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frameo_n,
  input  logic        valido_n,
  input  logic        dout,
  output logic [7:0]  byte_data,
  output logic        byte_last,
  output logic        byte_err,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [15:0] pkt_count,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    RECV = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [7:0]  shift_cap;

  logic        capture;
  logic        push_req;
  logic        push_last;
  logic        push_err;
  logic [7:0]  push_data;
  logic        clean_end;
  logic        pkt_end;

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push;
  logic [9:0]  head;

  // ------------------------------------------------------------------------
  // FSM state register
  // ------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= SYNC;
    end else begin
      state <= state_next;
    end
  end

  // ------------------------------------------------------------------------
  // FSM next-state logic. SYNC waits for a frame gap so that a packet already
  // in flight when reset is released is skipped entirely. In RECV any cycle
  // with frameo_n high ends the packet, whether cleanly or as an abort.
  // ------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      SYNC:    if (frameo_n)  state_next = IDLE;
      IDLE:    if (!frameo_n) state_next = RECV;
      RECV:    if (frameo_n)  state_next = IDLE;
      default: state_next = SYNC;
    endcase
  end

  // ------------------------------------------------------------------------
  // FSM output logic: decides bit capture and FIFO push requests.
  // shift_cap is the shift register with the current bit already inserted, so
  // a byte completing on this edge can be pushed without waiting a cycle.
  // ------------------------------------------------------------------------
  always_comb begin
    capture            = 1'b0;
    push_req           = 1'b0;
    push_last          = 1'b0;
    push_err           = 1'b0;
    clean_end          = 1'b0;
    pkt_end            = 1'b0;
    shift_cap          = shift_reg;
    shift_cap[bit_cnt] = dout;
    push_data          = shift_cap;

    case (state)
      IDLE: begin
        // First bit may coincide with the falling edge of the frame.
        capture = !frameo_n && !valido_n;
      end
      RECV: begin
        if (!valido_n) begin
          capture = 1'b1;
          pkt_end = frameo_n;
          if (bit_cnt == 3'd7) begin
            push_req  = 1'b1;
            push_last = frameo_n;
            clean_end = frameo_n;
          end else if (frameo_n) begin
            // Frame ended mid-byte: flush the zero-padded partial byte.
            push_req  = 1'b1;
            push_last = 1'b1;
            push_err  = 1'b1;
          end
        end else if (frameo_n) begin
          // Abort: shift_reg is already zero-padded, or 0x00 when nothing
          // is pending, so one push covers both cases.
          push_req  = 1'b1;
          push_last = 1'b1;
          push_err  = 1'b1;
          push_data = shift_reg;
          pkt_end   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------------
  // Byte assembly. The shift register is cleared after every completed byte
  // so that a later partial byte comes out zero-padded.
  // ------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
    end else if (pkt_end) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
    end else if (capture) begin
      bit_cnt   <= bit_cnt + 3'd1;
      shift_reg <= (bit_cnt == 3'd7) ? 8'd0 : shift_cap;
    end
  end

  // ------------------------------------------------------------------------
  // Packet counter and sticky overflow. A clean end is counted even when its
  // entry is dropped on a full FIFO.
  // ------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pkt_count <= 16'd0;
      overflow  <= 1'b0;
    end else begin
      if (clean_end) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // FIFO pointers carry one extra wrap bit to tell full from empty. A push
  // onto a full FIFO is accepted when the head is popped on the same edge.
  // A pop on an empty FIFO cannot occur because pop is qualified by
  // byte_valid.
  // ------------------------------------------------------------------------
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = byte_valid && byte_ready;
  assign push       = push_req && (!fifo_full || pop);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {push_err, push_last, push_data};
    end
  end

  // Outputs are masked while empty so stale storage never shows at the port.
  assign head       = mem[rd_ptr[AW-1:0]];
  assign byte_valid = !fifo_empty;
  assign byte_data  = byte_valid ? head[7:0] : 8'd0;
  assign byte_last  = byte_valid && head[8];
  assign byte_err   = byte_valid && head[9];

endmodule

// File: tb/tb_router_port_rx.sv
// tb_router_port_rx
// ---------------------------------------------------------------------------
// Scoreboard bench for router_port_rx. Stimulus tasks drive the router serial
// interface and push the hand-computed FIFO entries {err, last, data} into a
// queue; an independent monitor pops and compares every entry the DUT hands
// over on a valid/ready handshake. Packet counts, flags and the bit counter
// are compared against values the bench tracks itself.
// ---------------------------------------------------------------------------
module tb_router_port_rx;

  localparam int DEPTH = 16;

  logic        clock;
  logic        reset_n;
  logic        frameo_n;
  logic        valido_n;
  logic        dout;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_err;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] pkt_count;
  logic        overflow;

  logic [9:0]  sb_q[$];
  logic [15:0] exp_pkt;
  int          n_checks;
  int          n_fail;

  router_port_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .frameo_n   (frameo_n),
    .valido_n   (valido_n),
    .dout       (dout),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_err   (byte_err),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .pkt_count  (pkt_count),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of the router interface, returning 1 time unit after
  // the rising edge that consumed it.
  task automatic applyStimulus(input logic f, input logic v, input logic d);
    frameo_n = f;
    valido_n = v;
    dout     = d;
    @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input bit end_frame);
    for (int i = 0; i < n; i++) begin
      applyStimulus((end_frame && (i == n - 1)) ? 1'b0 : 1'b0, 1'b0, bits[i]);
      if (end_frame && (i == n - 2)) frameo_n = 1'b1;
    end
  endtask

  // Sends n bits LSB first; with end_frame the frame goes high on the last bit.
  task automatic send_seq(input logic [31:0] bits, input int n, input bit end_frame);
    for (int i = 0; i < n; i++) begin
      applyStimulus((end_frame && (i == n - 1)) ? 1'b1 : 1'b0, 1'b0, bits[i]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit end_frame);
    send_seq({24'd0, b}, 8, end_frame);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0);
  endtask

  task automatic push_exp(input logic err, input logic last, input logic [7:0] data);
    sb_q.push_back({err, last, data});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb_q.delete();
    exp_pkt = 16'd0;
    idle(2);
    reset_n = 1'b1;
  endtask

  // Waits a bounded number of cycles for the scoreboard to empty.
  task automatic wait_drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (sb_q.size() == 0 && !byte_valid) break;
      @(posedge clock);
      #1;
    end
    checkOutput({name, "_pending"}, sb_q.size(), 0);
    checkOutput({name, "_pkt_count"}, {16'd0, pkt_count}, {16'd0, exp_pkt});
  endtask

  // Monitor: compares every handshaked entry against the scoreboard head.
  always @(negedge clock) begin
    if (reset_n && byte_valid && byte_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_entry: got 0x%0h, expected no entry",
                 {byte_err, byte_last, byte_data});
      end else begin
        checkOutput("fifo_entry", {22'd0, byte_err, byte_last, byte_data},
                    {22'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    frameo_n   = 1'b1;
    valido_n   = 1'b1;
    dout       = 1'b0;
    byte_ready = 1'b1;
    exp_pkt    = 16'd0;

    do_reset();
    checkOutput("rst_byte_valid", byte_valid, 0);
    checkOutput("rst_byte_data", byte_data, 0);
    checkOutput("rst_byte_last", byte_last, 0);
    checkOutput("rst_byte_err", byte_err, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_pkt_count", pkt_count, 0);
    idle(2);

    $display("[TB] two-byte packet A5 3C");
    push_exp(1'b0, 1'b0, 8'hA5);
    push_exp(1'b0, 1'b1, 8'h3C);
    exp_pkt = exp_pkt + 16'd1;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b1);
    idle(2);
    wait_drain("pkt_a53c");

    $display("[TB] address bits, pads, then 0x81");
    // addr 0101 then 0x81 bits 1,0,0,0 -> 0x15; remaining 0,0,0,1 -> 0x08 partial
    push_exp(1'b0, 1'b0, 8'h15);
    push_exp(1'b1, 1'b1, 8'h08);
    send_seq(32'h5, 4, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("bit_cnt_pad_first", {29'd0, dut.bit_cnt}, 4);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("bit_cnt_pad_last", {29'd0, dut.bit_cnt}, 4);
    send_byte(8'h81, 1'b1);
    checkOutput("bit_cnt_after_end", {29'd0, dut.bit_cnt}, 0);
    idle(2);
    wait_drain("addr_pad");

    $display("[TB] 11-bit packet 0x7FF");
    push_exp(1'b0, 1'b0, 8'hFF);
    push_exp(1'b1, 1'b1, 8'h07);
    send_seq(32'h7FF, 11, 1'b1);
    idle(2);
    wait_drain("partial_7ff");

    $display("[TB] aborts with and without pending bits");
    push_exp(1'b1, 1'b1, 8'h05);
    send_seq(32'h5, 3, 1'b0);
    idle(2);
    push_exp(1'b0, 1'b0, 8'h42);
    push_exp(1'b1, 1'b1, 8'h00);
    send_byte(8'h42, 1'b0);
    idle(2);
    wait_drain("abort");

    $display("[TB] overflow with byte_ready low");
    byte_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      logic [7:0] b;
      b = 8'(i * 17 + 3);
      if (i < DEPTH) push_exp(1'b0, 1'b0, b);
      send_byte(b, (i == DEPTH));
    end
    exp_pkt = exp_pkt + 16'd1;
    idle(2);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_valid", byte_valid, 1);
    checkOutput("ovf_head", {22'd0, byte_err, byte_last, byte_data}, {22'd0, sb_q[0]});
    idle(3);
    checkOutput("ovf_head_stable", {22'd0, byte_err, byte_last, byte_data}, {22'd0, sb_q[0]});
    byte_ready = 1'b1;
    wait_drain("overflow");
    checkOutput("ovf_sticky", overflow, 1);
    do_reset();
    checkOutput("ovf_cleared", overflow, 0);
    checkOutput("ovf_rst_pkt", pkt_count, 0);
    idle(2);

    $display("[TB] reset mid-packet");
    send_seq(32'h1F, 5, 1'b0);
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    send_seq(32'h3FF, 10, 1'b1);
    idle(2);
    checkOutput("midrst_valid", byte_valid, 0);
    checkOutput("midrst_pkt", pkt_count, 0);
    push_exp(1'b0, 1'b0, 8'h5A);
    push_exp(1'b0, 1'b1, 8'hC3);
    exp_pkt = exp_pkt + 16'd1;
    send_byte(8'h5A, 1'b0);
    send_byte(8'hC3, 1'b1);
    idle(2);
    wait_drain("after_midrst");

    $display("[TB] pkt_count wrap");
    force dut.pkt_count = 16'hFFFE;
    #1;
    release dut.pkt_count;
    exp_pkt = 16'hFFFE;
    checkOutput("wrap_preload", pkt_count, 16'hFFFE);
    push_exp(1'b0, 1'b1, 8'h11);
    exp_pkt = exp_pkt + 16'd1;
    send_byte(8'h11, 1'b1);
    idle(2);
    wait_drain("wrap_ffff");
    push_exp(1'b0, 1'b1, 8'h22);
    exp_pkt = exp_pkt + 16'd1;
    send_byte(8'h22, 1'b1);
    idle(2);
    wait_drain("wrap_0000");
    checkOutput("wrap_zero", pkt_count, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
